// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide unit.
//   MD_W        : operand width (32)
//   md_op_e     : operation codes carried on md_op
//   md_state_e  : control FSM states
//   is_iter_op  : true for the ops that run the multi-cycle datapath
package md_pkg;

  localparam int MD_W = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Reserved code 7 falls outside the range and behaves like NONE.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op >= 3'(OP_MULT)) && (op <= 3'(OP_DIVU));
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core -- iterative multiply / restoring-divide datapath (no control).
//   clk, reset : clock and synchronous active-high reset
//   init       : load operands (multiply: acc={0,op_b}, divide: acc={0,op_a})
//   step       : perform one shift-add or one restoring-divide step
//   is_div     : selects the divide step instead of the multiply step
//   op_a, op_b : unsigned operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   result     : 64-bit accumulator, already including the step taken this cycle
// Configuration macro: MD_FAST_MULT_EN -- multiply is done in one cycle at init
// and the multiply step becomes a hold.
module md_iter_core
  import md_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              step,
  input  logic              is_div,
  input  logic [MD_W-1:0]   op_a,
  input  logic [MD_W-1:0]   op_b,
  output logic [2*MD_W-1:0] result
);

  logic [2*MD_W-1:0] acc_q;
  logic [2*MD_W-1:0] acc_step;
  logic [MD_W-1:0]   b_q;
  logic [MD_W+1:0]   div_diff;
`ifndef MD_FAST_MULT_EN
  logic [MD_W:0]     mul_sum;
`endif

  // One iteration. Divide: shift the remainder:quotient pair left by one and
  // try to subtract the divisor from the 33-bit partial remainder; a borrow
  // means the trial fails and the shifted value is kept. Multiply: the
  // multiplier sits in the low half and is consumed LSB first while the
  // partial product (with its carry) shifts in from the top.
  always_comb begin
    acc_step = acc_q;
    div_diff = {1'b0, acc_q[2*MD_W-1:MD_W-1]} - {2'b0, b_q};
`ifndef MD_FAST_MULT_EN
    mul_sum  = {1'b0, acc_q[2*MD_W-1:MD_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
`endif
    if (is_div) begin
      if (!div_diff[MD_W+1])
        acc_step = {div_diff[MD_W-1:0], acc_q[MD_W-2:0], 1'b1};
      else
        acc_step = {acc_q[2*MD_W-2:0], 1'b0};
    end else begin
`ifndef MD_FAST_MULT_EN
      acc_step = {mul_sum, acc_q[MD_W-1:1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (init) begin
      if (is_div) begin
        acc_q <= {{MD_W{1'b0}}, op_a};
        b_q   <= op_b;
      end else begin
`ifdef MD_FAST_MULT_EN
        acc_q <= (2*MD_W)'(op_a) * (2*MD_W)'(op_b);
`else
        acc_q <= {{MD_W{1'b0}}, op_b};
`endif
        b_q   <= op_a;
      end
    end else if (step) begin
      acc_q <= acc_step;
    end
  end

  // The write-back edge coincides with the final step, so expose the
  // post-step value.
  assign result = step ? acc_step : acc_q;

endmodule

// File: rtl/md_unit.sv
// md_unit -- MIPS HI/LO multiply/divide unit (mult, multu, div, divu, mthi, mtlo).
//   clk, reset : clock and synchronous active-high reset (clears HI, LO, FSM)
//   md_start   : E-stage op targets this unit
//   md_op      : md_op_e code
//   rs_e, rt_e : forwarded operands
//   hi_lo_rd   : read select, 0 = LO, 1 = HI
//   XALUOUT    : hi_lo_rd ? HI : LO (combinational)
//   busy       : registered, high while an iterative op is running
//   md_stall   : busy, or a mult/div op being issued this cycle
// Configuration macro: MD_FAST_MULT_EN -- MULT/MULTU finish one edge after start.
module md_unit
  import md_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [MD_W-1:0] rs_e,
  input  logic [MD_W-1:0] rt_e,
  input  logic            hi_lo_rd,
  output logic [MD_W-1:0] XALUOUT,
  output logic            busy,
  output logic            md_stall
);

  localparam int CNT_W = $clog2(ITER);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [MD_W-1:0]   rs_q, hi_q, lo_q, hi_wb, lo_wb;
  logic [2*MD_W-1:0] core_result;
  logic              start_iter, start_signed, start_div, a_neg, b_neg, last_cycle;
  logic [MD_W-1:0]   mag_a, mag_b;

  assign start_iter   = (state_q == IDLE) && md_start && is_iter_op(md_op);
  assign start_signed = (md_op == 3'(OP_MULT)) || (md_op == 3'(OP_DIV));
  assign start_div    = (md_op == 3'(OP_DIV))  || (md_op == 3'(OP_DIVU));
  assign a_neg        = start_signed && rs_e[MD_W-1];
  assign b_neg        = start_signed && rt_e[MD_W-1];
  assign mag_a        = a_neg ? -rs_e : rs_e;
  assign mag_b        = b_neg ? -rt_e : rt_e;

`ifdef MD_FAST_MULT_EN
  assign last_cycle = (state_q == RUN) && (!is_div_q || (cnt_q == CNT_W'(ITER-1)));
`else
  assign last_cycle = (state_q == RUN) && (cnt_q == CNT_W'(ITER-1));
`endif

  md_iter_core u_core (
    .clk    (clk),
    .reset  (reset),
    .init   (start_iter),
    .step   (state_q == RUN),
    .is_div ((state_q == RUN) ? is_div_q : start_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .result (core_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; anything issued while RUN is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_iter) state_d = RUN;
      RUN:     if (last_cycle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; busy comes straight from the state flop.
  always_comb begin
    busy     = (state_q == RUN);
    md_stall = busy || (md_start && is_iter_op(md_op));
    XALUOUT  = hi_lo_rd ? hi_q : lo_q;
  end

  // Per-operation context captured at start. The raw rs_e is kept because a
  // divide by zero returns it in HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rs_q       <= '0;
    end else if (start_iter) begin
      cnt_q      <= '0;
      is_div_q   <= start_div;
      neg_res_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (rt_e == '0);
      rs_q       <= rs_e;
    end else if (state_q == RUN) begin
      cnt_q <= last_cycle ? '0 : cnt_q + 1'b1;
    end
  end

  // Sign fix and result mapping. 0x80000000 / -1 needs no special case: the
  // magnitude quotient 0x80000000 negates to itself with remainder 0.
  always_comb begin
    {hi_wb, lo_wb} = neg_res_q ? -core_result : core_result;
    if (is_div_q) begin
      if (div_zero_q) begin
        lo_wb = '1;
        hi_wb = rs_q;
      end else begin
        lo_wb = neg_res_q ? -core_result[MD_W-1:0]      : core_result[MD_W-1:0];
        hi_wb = neg_rem_q ? -core_result[2*MD_W-1:MD_W] : core_result[2*MD_W-1:MD_W];
      end
    end
  end

  // HI/LO registers: iterative write-back or an idle-time MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last_cycle) begin
      hi_q <= hi_wb;
      lo_q <= lo_wb;
    end else if ((state_q == IDLE) && md_start) begin
      if (md_op == 3'(OP_MTHI)) hi_q <= rs_e;
      if (md_op == 3'(OP_MTLO)) lo_q <= rs_e;
    end
  end

  // A mult/div issued while RUN would be silently lost.
  a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
    !((state_q == RUN) && md_start && is_iter_op(md_op)));

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- self-checking bench for md_unit: directed vector table, a few
// multi-cycle sequences (MTHI/MTLO, MTLO during RUN, reset mid-RUN, reserved
// op) and randomized ops compared against an arithmetic reference model.
// Honours MD_FAST_MULT_EN for the expected multiply latency.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_e = '0, rt_e = '0;
  logic        hi_lo_rd = 1'b0;
  logic [31:0] XALUOUT;
  logic        busy, md_stall;

  int checks = 0;
  int errors = 0;

  md_unit #(.ITER(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_e     (rs_e),
    .rt_e     (rt_e),
    .hi_lo_rd (hi_lo_rd),
    .XALUOUT  (XALUOUT),
    .busy     (busy),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  // Hard limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic read_hi_lo(output logic [31:0] hi, output logic [31:0] lo);
    hi_lo_rd = 1'b0; #1; lo = XALUOUT;
    hi_lo_rd = 1'b1; #1; hi = XALUOUT;
    hi_lo_rd = 1'b0;
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint    sp;
    logic [63:0] up;
    int        sa, sb;
    hi = 'x; lo = 'x;
    case (op)
      3'(OP_MULT): begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = 64'(sp);
      end
      3'(OP_MULTU): begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      3'(OP_DIV): begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin
          sa = a; sb = b;
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      3'(OP_DIVU): begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Issues one mult/div op from IDLE and checks stall, busy length,
  // HI/LO hold during RUN, final HI/LO and stall release.
  task automatic applyStimulus(input string name, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo, got_hi, got_lo;
    int lat, exp_lat;
    bit stall_ok, hold_ok;
    read_hi_lo(old_hi, old_lo);
    exp_lat = 32;
`ifdef MD_FAST_MULT_EN
    if (op == 3'(OP_MULT) || op == 3'(OP_MULTU)) exp_lat = 1;
`endif
    md_start = 1'b1; md_op = op; rs_e = a; rt_e = b;
    #1;
    checkOutput({name, " stall_at_start"}, 32'(md_stall), 32'd1);
    tick();
    md_start = 1'b0; md_op = 3'(OP_NONE); rs_e = $urandom; rt_e = $urandom;
    lat = 0; stall_ok = 1'b1; hold_ok = 1'b1;
    while (busy === 1'b1 && lat < 100) begin
      if (md_stall !== 1'b1) stall_ok = 1'b0;
      hi_lo_rd = lat[0];
      #1;
      if (XALUOUT !== (lat[0] ? old_hi : old_lo)) hold_ok = 1'b0;
      hi_lo_rd = 1'b0;
      lat++;
      tick();
    end
    checkOutput({name, " busy_cycles"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, " stall_while_busy"}, 32'(stall_ok), 32'd1);
    checkOutput({name, " hold_while_busy"}, 32'(hold_ok), 32'd1);
    checkOutput({name, " stall_after"}, 32'(md_stall), 32'd0);
    read_hi_lo(got_hi, got_lo);
    checkOutput({name, " HI"}, got_hi, exp_hi);
    checkOutput({name, " LO"}, got_lo, exp_lo);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] hi, lo, exp_hi, exp_lo, a, b;
    logic [2:0]  op;
    int n;

    vecs[0] = '{"multu_ffff_x2", 3'(OP_MULTU), 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1] = '{"mult_m3_x5",    3'(OP_MULT),  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{"div_m7_2",      3'(OP_DIV),   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7_0",      3'(OP_DIVU),  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{"div_ovf",       3'(OP_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"div_m7_0",      3'(OP_DIV),   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{"div_7_m2",      3'(OP_DIV),   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{"mult_min_min",  3'(OP_MULT),  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{"multu_max_max", 3'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9] = '{"divu_100_7",    3'(OP_DIVU),  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};

    // Reset state.
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset md_stall", 32'(md_stall), 32'd0);
    read_hi_lo(hi, lo);
    checkOutput("reset HI", hi, 32'd0);
    checkOutput("reset LO", lo, 32'd0);
    tick();

    // Directed vectors.
    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI then MTLO: one-edge latency, never busy, never stalling.
    md_start = 1'b1; md_op = 3'(OP_MTHI); rs_e = 32'h1234_5678;
    #1;
    checkOutput("mthi stall", 32'(md_stall), 32'd0);
    tick();
    md_op = 3'(OP_MTLO); rs_e = 32'h0BAD_F00D;
    checkOutput("mthi busy", 32'(busy), 32'd0);
    hi_lo_rd = 1'b1; #1;
    checkOutput("mthi HI", XALUOUT, 32'h1234_5678);
    hi_lo_rd = 1'b0;
    tick();
    md_start = 1'b0; md_op = 3'(OP_NONE);
    read_hi_lo(hi, lo);
    checkOutput("mtlo LO", lo, 32'h0BAD_F00D);
    checkOutput("mtlo HI kept", hi, 32'h1234_5678);
    tick();

    // Reserved op code behaves as NONE.
    md_start = 1'b1; md_op = 3'(OP_RSVD); rs_e = 32'hAAAA_5555; rt_e = 32'd3;
    #1;
    checkOutput("rsvd stall", 32'(md_stall), 32'd0);
    tick();
    md_start = 1'b0; md_op = 3'(OP_NONE);
    checkOutput("rsvd busy", 32'(busy), 32'd0);
    read_hi_lo(hi, lo);
    checkOutput("rsvd LO kept", lo, 32'h0BAD_F00D);
    tick();

    // MTLO issued while RUN is ignored.
    md_start = 1'b1; md_op = 3'(OP_MULTU); rs_e = 32'h0000_1234; rt_e = 32'h10;
    tick();
    md_start = 1'b0; md_op = 3'(OP_NONE);
    tick();
    md_start = 1'b1; md_op = 3'(OP_MTLO); rs_e = 32'hDEAD_BEEF;
`ifdef MD_FAST_MULT_EN
    md_start = 1'b0;
`endif
    tick();
    md_start = 1'b0; md_op = 3'(OP_NONE);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    checkOutput("mtlo_in_run busy_done", 32'(busy), 32'd0);
    read_hi_lo(hi, lo);
    checkOutput("mtlo_in_run LO", lo, 32'h0001_2340);
    checkOutput("mtlo_in_run HI", hi, 32'h0000_0000);
    tick();

    // Reset in cycle 10 of a divide discards it and clears HI/LO.
    md_start = 1'b1; md_op = 3'(OP_DIV); rs_e = 32'hFFFF_FF9C; rt_e = 32'd3;
    tick();
    md_start = 1'b0; md_op = 3'(OP_NONE);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("midrun busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrun busy after reset", 32'(busy), 32'd0);
    read_hi_lo(hi, lo);
    checkOutput("midrun HI", hi, 32'd0);
    checkOutput("midrun LO", lo, 32'd0);
    tick();
    applyStimulus("post_reset divu_100_7", 3'(OP_DIVU), 32'd100, 32'd7, 32'd2, 32'd14);

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      ref_model(op, a, b, exp_hi, exp_lo);
      applyStimulus($sformatf("rand%0d op%0d %h %h", i, op, a, b), op, a, b, exp_hi, exp_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
